jt89_gg_serial: RTL

Stereo serializer directly downstream of the Game Gear stereo mixer. Samples the mixer's signed `sound_l`/`sound_r` words on a sample strobe, double-buffers them and shifts them out MSB-first as a left-justified serial stream (`sck`/`ws`/`sd`) for an external DAC. It generates its own bit clock from a clock-enable input and flags samples lost to overrun.

---
 rtl/jt89_gg_serial.sv | 86 ++++++++
 1 files changed

// File: rtl/jt89_gg_serial.sv
// jt89_gg_serial: double-buffered left-justified serializer for the Game Gear stereo mix
module jt89_gg_serial #(
    parameter int bw = 9,
    parameter int ow = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic          sample,
    input  logic [bw+1:0] sound_l,
    input  logic [bw+1:0] sound_r,
    output logic          sck,
    output logic          ws,
    output logic          sd,
    output logic          overrun
);
    localparam int CW  = $clog2(2*ow);
    localparam int PAD = ow - bw - 2;
    localparam logic [1:0] IDLE = 2'd0, START = 2'd1, RUN = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [CW-1:0]   bitcnt_q, bitcnt_d, bit_nxt;
    logic            sck_q, sck_d, ws_q, ws_d, sd_q, sd_d, ov_q, ov_d, fresh_q, fresh_d;
    logic            load, step, fall;
    logic [bw+1:0]   hold_l_q, hold_l_d, hold_r_q, hold_r_d;
    logic [ow-1:0]   shift_l_q, shift_l_d, shift_r_q, shift_r_d, fmt_l, fmt_r;
    logic [2*ow-1:0] frame;

    // MSB-aligned words: the sign bit lands on the word MSB, low bits zero
    assign fmt_l   = ow'(hold_l_q) << PAD;
    assign fmt_r   = ow'(hold_r_q) << PAD;
    assign frame   = {shift_l_q, shift_r_q};
    assign bit_nxt = (bitcnt_q == CW'(2*ow-1)) ? '0 : bitcnt_q + CW'(1);
    assign load    = cen && (state_q == START || (state_q == RUN && sck_q && bit_nxt == '0));
    assign step    = cen && state_q == RUN && !load;
    assign fall    = step && sck_q;

    // Next state: the frame load takes the old hold, so a coincident sample is never an overrun
    always_comb begin
        hold_l_d  = sample ? sound_l : hold_l_q;
        hold_r_d  = sample ? sound_r : hold_r_q;
        fresh_d   = sample | (fresh_q & ~load);
        ov_d      = sample & fresh_q & ~load;
        state_d   = load ? RUN : (state_q == IDLE && sample) ? START : state_q;
        shift_l_d = load ? fmt_l : shift_l_q;
        shift_r_d = load ? fmt_r : shift_r_q;
        sck_d     = load ? 1'b0 : step ? ~sck_q : sck_q;
        bitcnt_d  = load ? '0 : fall ? bit_nxt : bitcnt_q;
        ws_d      = load ? 1'b0 : fall ? (bit_nxt >= CW'(ow)) : ws_q;
        sd_d      = load ? fmt_l[ow-1] : fall ? frame[CW'(2*ow-1) - bit_nxt] : sd_q;
    end

    // State registers; reset aborts any frame in progress and returns to IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            bitcnt_q  <= '0;
            sck_q     <= 1'b0;
            ws_q      <= 1'b0;
            sd_q      <= 1'b0;
            ov_q      <= 1'b0;
            fresh_q   <= 1'b0;
            hold_l_q  <= '0;
            hold_r_q  <= '0;
            shift_l_q <= '0;
            shift_r_q <= '0;
        end else begin
            state_q   <= state_d;
            bitcnt_q  <= bitcnt_d;
            sck_q     <= sck_d;
            ws_q      <= ws_d;
            sd_q      <= sd_d;
            ov_q      <= ov_d;
            fresh_q   <= fresh_d;
            hold_l_q  <= hold_l_d;
            hold_r_q  <= hold_r_d;
            shift_l_q <= shift_l_d;
            shift_r_q <= shift_r_d;
        end
    end

    assign sck     = sck_q;
    assign ws      = ws_q;
    assign sd      = sd_q;
    assign overrun = ov_q;
endmodule
